// File: rtl/dvi_pixel_packer_if.sv
// Bundle between the DVI source / pixel FIFO (master) and the pixel packer (slave).
interface dvi_pixel_packer_if;
    logic        capture_en;
    logic        de;
    logic        vsync;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        wrfull;
    logic        wrclk;
    logic        wrreq;
    logic [43:0] data;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    modport master (
        output capture_en, de, vsync, pix_r, pix_g, pix_b, wrfull,
        input  wrclk, wrreq, data, frame_start, frame_cnt, drop_cnt, overflow
    );

    modport slave (
        input  capture_en, de, vsync, pix_r, pix_g, pix_b, wrfull,
        output wrclk, wrreq, data, frame_start, frame_cnt, drop_cnt, overflow
    );
endinterface

// File: rtl/dvi_pixel_packer.sv
// Packs visible DVI pixels into {x, y, r, g, b} FIFO words, frame-locked on VSYNC,
// dropping (and counting) pixels while the FIFO reports full.
module dvi_pixel_packer #(
    parameter int   H_ACTIVE = 640,
    parameter int   V_ACTIVE = 480,
    parameter logic VS_POL   = 1'b0
) (
    input logic               clk_25_i,
    input logic               rst_i,
    dvi_pixel_packer_if.slave bus
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    typedef enum logic [0:0] {
        S_SYNC  = 1'b0,
        S_FRAME = 1'b1
    } state_e;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        de_q, de_prev_q, vsync_q, vs_act_prev_q, cap_q;
    logic [7:0]  pix_r_q, pix_g_q, pix_b_q;
    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        wrreq_q, wrreq_d;
    logic [43:0] data_q, data_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        overflow_q, overflow_d;
    logic        vs_act_s, vs_edge_s, de_fall_s, pix_valid_s;

    assign vs_act_s  = (vsync_q == VS_POL);
    assign vs_edge_s = vs_act_s & ~vs_act_prev_q;
    assign de_fall_s = de_prev_q & ~de_q;

    // Input register stage plus the delayed copies used for edge detection
    always_ff @(posedge clk_25_i or posedge rst_i) begin
        if (rst_i) begin
            de_q          <= 1'b0;
            de_prev_q     <= 1'b0;
            vsync_q       <= ~VS_POL;
            vs_act_prev_q <= 1'b0;
            cap_q         <= 1'b0;
            pix_r_q       <= 8'd0;
            pix_g_q       <= 8'd0;
            pix_b_q       <= 8'd0;
        end else begin
            de_q          <= bus.de;
            de_prev_q     <= de_q;
            vsync_q       <= bus.vsync;
            vs_act_prev_q <= vs_act_s;
            cap_q         <= bus.capture_en;
            pix_r_q       <= bus.pix_r;
            pix_g_q       <= bus.pix_g;
            pix_b_q       <= bus.pix_b;
        end
    end

    // Frame/coordinate state and registered outputs
    always_ff @(posedge clk_25_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_SYNC;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            wrreq_q       <= 1'b0;
            data_q        <= 44'd0;
            drop_cnt_q    <= 16'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            wrreq_q       <= wrreq_d;
            data_q        <= data_d;
            drop_cnt_q    <= drop_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    // Next-state logic; a VSYNC edge overrides any pixel or line end in the same cycle
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        pix_valid_s   = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (vs_edge_s && cap_q) begin
                    state_d       = S_FRAME;
                    x_d           = 10'd0;
                    y_d           = 10'd0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_FRAME: begin
                if (vs_edge_s) begin
                    if (cap_q) begin
                        x_d           = 10'd0;
                        y_d           = 10'd0;
                        frame_start_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + 8'd1;
                    end else begin
                        state_d = S_SYNC;
                    end
                end else begin
                    pix_valid_s = de_q && (x_q < H_LIM) && (y_q < V_LIM) && !vs_act_s;
                    if (de_q) begin
                        x_d = sat_inc10(x_q);
                    end else if (de_fall_s) begin
                        x_d = 10'd0;
                        y_d = sat_inc10(y_q);
                    end else begin
                        x_d = x_q;
                    end
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // Output stage: write or drop the current visible pixel using pre-increment x/y
    always_comb begin
        wrreq_d    = pix_valid_s & ~bus.wrfull;
        data_d     = data_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (wrreq_d) begin
            data_d = {x_q, y_q, pix_r_q, pix_g_q, pix_b_q};
        end else begin
            data_d = data_q;
        end
        if (pix_valid_s && bus.wrfull) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            overflow_d = 1'b1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    assign bus.wrclk       = clk_25_i;
    assign bus.wrreq       = wrreq_q;
    assign bus.data        = data_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_dvi_pixel_packer.sv
// Directed frame sequence with random pixel data and FIFO-full patterns, checked
// against a frame/line/pixel reference model of the expected FIFO word stream.
module tb_dvi_pixel_packer;

    localparam int   H      = 40;
    localparam int   V      = 6;
    localparam logic VS_POL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dvi_pixel_packer_if bus ();

    dvi_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .VS_POL(VS_POL)) dut (
        .clk_25_i (clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    logic [43:0] rcv[$];
    logic [43:0] exp_q[$];
    int          fs_seen   = 0;
    int          fs_exp    = 0;
    bit          capturing = 1'b0;
    int          line_idx  = 0;
    logic [7:0]  fcnt_exp  = 8'd0;
    int          drops_exp = 0;
    bit          ovf_exp   = 1'b0;
    bit          pend_full = 1'b0;

    // Collects every FIFO write and counts frame_start cycles
    always @(negedge clk) begin
        if (bus.wrreq === 1'b1) rcv.push_back(bus.data);
        if (bus.frame_start === 1'b1) fs_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One input cycle; wrfull for a pixel is presented one cycle after the pixel itself
    task automatic step(input logic d, input logic vs, input logic cap,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input bit full);
        @(negedge clk);
        bus.wrfull     = pend_full;
        pend_full      = full;
        bus.de         = d;
        bus.vsync      = vs;
        bus.capture_en = cap;
        bus.pix_r      = r;
        bus.pix_g      = g;
        bus.pix_b      = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, ~VS_POL, 1'($urandom), 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic vsync_pulse(input bit cap);
        for (int i = 0; i < 3; i++) step(1'b0, VS_POL, cap, 8'd0, 8'd0, 8'd0, 1'b0);
        idle(4);
        if (cap) begin
            capturing = 1'b1;
            line_idx  = 0;
            fcnt_exp  = fcnt_exp + 8'd1;
            fs_exp++;
        end else begin
            capturing = 1'b0;
        end
    endtask

    // mode 0: constant 12/34/56, 1: random colour + random full, 2: random colour, full for x 10..19
    task automatic pixel(input int i, input int mode);
        logic [7:0] r, g, b;
        bit         f;
        if (mode == 0) {r, g, b} = 24'h123456;
        else           {r, g, b} = 24'($urandom);
        f = (mode == 1) ? ($urandom_range(0, 15) == 0) : (mode == 2 && i >= 10 && i < 20);
        step(1'b1, ~VS_POL, 1'($urandom), r, g, b, f);
        if (capturing && i < H && line_idx < V) begin
            if (f) begin
                drops_exp++;
                ovf_exp = 1'b1;
            end else begin
                exp_q.push_back({10'(i), 10'(line_idx), r, g, b});
            end
        end
    endtask

    task automatic drive_line(input int len, input int mode, input bit lat_chk);
        for (int i = 0; i < len; i++) begin
            pixel(i, mode);
            if (lat_chk && i == 1) chk("latency_early", 64'(bus.wrreq), 64'd0);
            if (lat_chk && i == 2) begin
                chk("latency_wrreq", 64'(bus.wrreq), 64'd1);
                chk("first_word", 64'(bus.data), 64'({10'd0, 10'd0, 8'h12, 8'h34, 8'h56}));
            end
        end
        idle(4);
        line_idx++;
    endtask

    task automatic check_all(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_count"}, 64'(rcv.size()), 64'(exp_q.size()));
        for (int i = 0; i < rcv.size() && i < exp_q.size(); i++)
            if (rcv[i] !== exp_q[i]) bad++;
        chk({tag, "_words"}, 64'(bad), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(drops_exp));
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'(ovf_exp));
        chk({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(fcnt_exp));
        rcv.delete();
        exp_q.delete();
    endtask

    task automatic reset_midline(input int at);
        int bad;
        for (int i = 0; i < at; i++) pixel(i, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_wrreq", 64'(bus.wrreq), 64'd0);
        chk("rst_data", 64'(bus.data), 64'd0);
        chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        bad = 0;
        for (int i = 0; i < rcv.size(); i++)
            if (i >= exp_q.size() || rcv[i] !== exp_q[i]) bad++;
        chk("rst_prefix", 64'(bad), 64'd0);
        chk("rst_lag", 64'(rcv.size() + 2 >= exp_q.size()), 64'd1);
        rcv.delete();
        exp_q.delete();
        capturing = 1'b0;
        fcnt_exp  = 8'd0;
        drops_exp = 0;
        ovf_exp   = 1'b0;
        pend_full = 1'b0;
        bus.wrfull = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = at; i < H; i++) pixel(i, 1);
        idle(4);
        line_idx++;
    endtask

    initial begin
        bus.capture_en = 1'b0;
        bus.de         = 1'b0;
        bus.vsync      = ~VS_POL;
        bus.pix_r      = 8'd0;
        bus.pix_g      = 8'd0;
        bus.pix_b      = 8'd0;
        bus.wrfull     = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_wrreq", 64'(bus.wrreq), 64'd0);
        chk("reset_data", 64'(bus.data), 64'd0);
        chk("reset_frame_start", 64'(bus.frame_start), 64'd0);
        chk("reset_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        chk("reset_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("reset_overflow", 64'(bus.overflow), 64'd0);
        chk("wrclk_follows_clk", 64'(bus.wrclk), 64'(clk));
        rst = 1'b0;
        idle(3);

        // Nothing is written before the first accepted frame start
        drive_line(H, 1, 1'b0);
        chk("pre_frame_writes", 64'(rcv.size()), 64'd0);
        rcv.delete();
        exp_q.delete();

        // Frame 1: first line with fixed colour, latency and frame_start checks
        vsync_pulse(1'b1);
        chk("frame1_cnt", 64'(bus.frame_cnt), 64'd1);
        chk("frame1_start_pulses", 64'(fs_seen), 64'd1);
        drive_line(H, 0, 1'b1);
        chk("line0_count", 64'(rcv.size()), 64'(H));
        chk("line0_last_x", 64'(rcv[rcv.size() - 1][43:34]), 64'(H - 1));
        drive_line(H, 2, 1'b0);
        chk("drop10_cnt", 64'(bus.drop_cnt), 64'd10);
        chk("drop10_overflow", 64'(bus.overflow), 64'd1);
        drive_line(H + 12, 1, 1'b0);
        for (int l = 3; l < V + 2; l++) drive_line(H, 1, 1'b0);
        vsync_pulse(1'b1);
        check_all("frame1");
        chk("overflow_sticky", 64'(bus.overflow), 64'd1);

        // Frame 2 is abandoned by a capture_en=0 vsync, capture then resumes
        drive_line(H, 1, 1'b0);
        drive_line(H, 1, 1'b0);
        vsync_pulse(1'b0);
        drive_line(H, 1, 1'b0);
        drive_line(H, 1, 1'b0);
        check_all("frame2");
        vsync_pulse(1'b1);
        drive_line(H, 1, 1'b0);
        chk("resume_first_xy", 64'(rcv[0][43:24]), 64'd0);
        drive_line(H, 1, 1'b0);

        // Reset mid-line: no partial frame after release, capture at next vsync
        reset_midline(15);
        drive_line(H, 1, 1'b0);
        drive_line(H, 1, 1'b0);
        check_all("after_reset");
        vsync_pulse(1'b1);
        chk("post_reset_frame_cnt", 64'(bus.frame_cnt), 64'd1);
        for (int l = 0; l < V; l++) drive_line(H, 1, 1'b0);
        vsync_pulse(1'b1);
        check_all("post_reset_frame");
        chk("frame_start_total", 64'(fs_seen), 64'(fs_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
